// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer: FSM states,
// base opcodes, instruction classes and PC source selects.
package seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        CL_R      = 3'd0,
        CL_IMM    = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_JAL    = 3'd5,
        CL_LUI    = 3'd6,
        CL_AUIPC  = 3'd7
    } opclass_t;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;

    // Register-register compares and ALU ops take operand B from rs2.
    function automatic logic uses_imm(input opclass_t cls);
        return !(cls == CL_R || cls == CL_BRANCH);
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Purely combinational map from the 7-bit base opcode to an instruction class
// and a legality flag.
module opcode_classifier
    import seq_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   op_class,
    output logic       legal
);

    always_comb begin
        op_class = CL_R;
        legal    = 1'b1;
        case (opcode)
            OP_R:      op_class = CL_R;
            OP_IMM:    op_class = CL_IMM;
            OP_LOAD:   op_class = CL_LOAD;
            OP_STORE:  op_class = CL_STORE;
            OP_BRANCH: op_class = CL_BRANCH;
            OP_JAL:    op_class = CL_JAL;
            OP_LUI:    op_class = CL_LUI;
            OP_AUIPC:  op_class = CL_AUIPC;
            default:   legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb for one instruction at a
// time over a shared memory port, with stall hold and memory timeout fault.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       stall,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       alusrc,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       fault,
    output logic [2:0] state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    opclass_t        class_q, class_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fault_q, fault_d;

    opclass_t        dec_class;
    logic            dec_legal;
    logic            mem_wait;
    logic            timed_out;

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MEM);
    // The final permitted waiting cycle: a late mem_ready here still completes.
    assign timed_out = mem_wait && !mem_ready && (cnt_q >= CNT_LAST);

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        fault_d = fault_q;
        cnt_d   = '0;
        if (mem_wait && !mem_ready) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (!stall) begin
                    if (dec_legal) begin
                        class_d = dec_class;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (class_q == CL_LOAD || class_q == CL_STORE) begin
                        state_d = S_MEM;
                    end else if (class_q == CL_BRANCH) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == CL_STORE) ? S_FETCH : S_WB;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_WB: begin
                if (!stall) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = S_HALT;
                fault_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            class_q <= CL_R;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Strobes are gated by rst_n so an in-flight request drops the instant reset asserts.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        reg_write  = 1'b0;
        alusrc     = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                S_EXEC: begin
                    alusrc = uses_imm(class_q);
                    if (class_q == CL_BRANCH) begin
                        pc_src = branch_taken ? PC_BRANCH : PC_PLUS4;
                        if (!stall) begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (class_q == CL_STORE);
                    alusrc  = 1'b1;
                    if (mem_ready && class_q == CL_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WB: begin
                    mem_to_reg = (class_q == CL_LOAD);
                    pc_src     = (class_q == CL_JAL) ? PC_JAL : PC_PLUS4;
                    if (!stall) begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: a per-instruction phase model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_multicycle_sequencer;

  localparam int TO = 3;
  localparam int W  = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       stall = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write, reg_write, alusrc;
  logic       mem_to_reg, retire, fault;
  logic [1:0] pc_src;
  logic [2:0] state;

  logic [2*W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_cyc = 0;
  int exp_retires = 0;
  int act_retires = 0;

  logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};

  // clock / reset block
  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .stall        (stall),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .alusrc       (alusrc),
    .mem_to_reg   (mem_to_reg),
    .retire       (retire),
    .fault        (fault),
    .state        (state)
  );

  // Expected entry = {mask, value}; value bit order:
  // [2:0] state [3] mem_req [4] mem_we [5] ir_write [6] pc_write [8:7] pc_src
  // [9] reg_write [10] alusrc [11] mem_to_reg [12] retire [13] fault
  function automatic logic [2*W-1:0] ev(input logic [2:0] st, input bit req, input bit we,
                                        input bit irw, input bit pcw, input logic [1:0] src,
                                        input bit rw, input bit alu, input bit alu_care,
                                        input bit m2r, input bit ret, input bit flt);
    logic [W-1:0] v;
    logic [W-1:0] m;
    v = {flt, ret, m2r, alu, rw, src, pcw, irw, we, req, st};
    m = '1;
    if (!pcw) m[8:7] = 2'b00;
    if (!alu_care) m[10] = 1'b0;
    return {m, v};
  endfunction

  function automatic logic [2*W-1:0] rst_e();
    logic [W-1:0] ones;
    ones = '1;
    return {ones, {W{1'b0}}};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 8; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // driver tasks
  task automatic cyc(input bit rn, input bit rdy, input bit stl, input bit tk,
                     input logic [6:0] op, input logic [2*W-1:0] e);
    @(posedge clk);
    #1;
    rst_n = rn;
    mem_ready = rdy;
    stall = stl;
    branch_taken = tk;
    opcode = op;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rb(), rb(), rb(), rnd_op(), rst_e());
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, rb(), rb(), rb(), rnd_op(), ev(3'd5, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0, 1));
  endtask

  // Reference model: an instruction is a run of phases, each lengthened by
  // memory waits (fetch/mem) or stall cycles (decode/exec/wb).
  task automatic run_instr(input logic [6:0] op, input int fw, input int sd, input int se,
                           input int mw, input int sw, input bit tk, input bit abort_mem,
                           output bit halted);
    bit is_r, is_ld, is_st, is_br, is_jal, alu;
    is_r   = (op == 7'b0110011);
    is_ld  = (op == 7'b0000011);
    is_st  = (op == 7'b0100011);
    is_br  = (op == 7'b1100011);
    is_jal = (op == 7'b1101111);
    alu    = !(is_r || is_br);
    halted = 1'b0;
    for (int i = 0; i < fw && i < TO; i++)
      cyc(1'b1, 1'b0, rb(), rb(), rnd_op(), ev(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    if (fw >= TO) begin
      halted = 1'b1;
      return;
    end
    cyc(1'b1, 1'b1, rb(), rb(), rnd_op(), ev(3'd0, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < sd; i++)
      cyc(1'b1, rb(), 1'b1, rb(), op, ev(3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, rb(), 1'b0, rb(), op, ev(3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    if (!is_legal(op)) begin
      halted = 1'b1;
      return;
    end
    for (int i = 0; i < se; i++)
      cyc(1'b1, rb(), 1'b1, rb(), rnd_op(), ev(3'd2, 0, 0, 0, 0, 2'd0, 0, alu, 1, 0, 0, 0));
    if (is_br) begin
      cyc(1'b1, rb(), 1'b0, tk, rnd_op(),
          ev(3'd2, 0, 0, 0, 1, tk ? 2'd1 : 2'd0, 0, alu, 1, 0, 1, 0));
      exp_retires++;
      return;
    end
    cyc(1'b1, rb(), 1'b0, rb(), rnd_op(), ev(3'd2, 0, 0, 0, 0, 2'd0, 0, alu, 1, 0, 0, 0));
    if (is_ld || is_st) begin
      if (abort_mem) begin
        cyc(1'b1, 1'b0, rb(), rb(), rnd_op(), ev(3'd3, 1, is_st, 0, 0, 2'd0, 0, 1, 1, 0, 0, 0));
        return;
      end
      for (int i = 0; i < mw && i < TO; i++)
        cyc(1'b1, 1'b0, rb(), rb(), rnd_op(), ev(3'd3, 1, is_st, 0, 0, 2'd0, 0, 1, 1, 0, 0, 0));
      if (mw >= TO) begin
        halted = 1'b1;
        return;
      end
      cyc(1'b1, 1'b1, rb(), rb(), rnd_op(),
          ev(3'd3, 1, is_st, 0, is_st, 2'd0, 0, 1, 1, 0, is_st, 0));
      if (is_st) begin
        exp_retires++;
        return;
      end
    end
    for (int i = 0; i < sw; i++)
      cyc(1'b1, rb(), 1'b1, rb(), rnd_op(), ev(3'd4, 0, 0, 0, 0, 2'd0, 0, 0, 0, is_ld, 0, 0));
    cyc(1'b1, rb(), 1'b0, rb(), rnd_op(),
        ev(3'd4, 0, 0, 0, 1, is_jal ? 2'd2 : 2'd0, 1, 0, 0, is_ld, 1, 0));
    exp_retires++;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    logic [W-1:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {fault, retire, mem_to_reg, alusrc, reg_write, pc_src, pc_write,
             ir_write, mem_we, mem_req, state};
      if (retire) act_retires++;
      n_tests++;
      if ((act & e[2*W-1:W]) !== (e[W-1:0] & e[2*W-1:W])) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got %h expected %h (mask %h)",
                 n_cyc, act, e[W-1:0], e[2*W-1:W]);
      end
      n_cyc++;
    end
  end

  initial begin
    bit h;
    logic [6:0] op;
    int fw, mw;
    reset_cycles(3);
    // R-type, zero waits
    run_instr(7'b0110011, 0, 0, 0, 0, 0, 1'b0, 1'b0, h);
    // LOAD with 2 memory wait cycles in MEM
    run_instr(7'b0000011, 0, 0, 0, 2, 0, 1'b0, 1'b0, h);
    // BRANCH taken / not taken
    run_instr(7'b1100011, 0, 0, 0, 0, 0, 1'b1, 1'b0, h);
    run_instr(7'b1100011, 0, 0, 0, 0, 0, 1'b0, 1'b0, h);
    // JAL with stalls in WB
    run_instr(7'b1101111, 0, 1, 0, 0, 2, 1'b0, 1'b0, h);
    // STORE stalled two cycles in EXEC, completes
    run_instr(7'b0100011, 0, 0, 2, 1, 0, 1'b0, 1'b0, h);
    // STORE stalled in EXEC, reset asserted mid-MEM
    run_instr(7'b0100011, 0, 0, 2, 0, 0, 1'b0, 1'b1, h);
    reset_cycles(2);
    // illegal opcode halts until reset
    run_instr(7'b1111111, 0, 0, 0, 0, 0, 1'b0, 1'b0, h);
    halt_cycles(4);
    reset_cycles(1);
    // fetch timeout, then mem_ready arriving on the last allowed cycle
    run_instr(7'b0010011, TO, 0, 0, 0, 0, 1'b0, 1'b0, h);
    halt_cycles(3);
    reset_cycles(1);
    run_instr(7'b0010011, TO - 1, 0, 0, 0, 0, 1'b0, 1'b0, h);
    run_instr(7'b0000011, 0, 0, 0, TO - 1, 0, 1'b0, 1'b0, h);
    run_instr(7'b0000011, 0, 0, 0, TO, 0, 1'b0, 1'b0, h);
    halt_cycles(2);
    reset_cycles(1);
    // randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do op = rnd_op(); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      fw = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
      mw = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
      run_instr(op, fw, rb() ? 0 : $urandom_range(1, 2), rb() ? 0 : $urandom_range(1, 2),
                mw, rb() ? 0 : $urandom_range(1, 2), rb(), ($urandom_range(0, 24) == 0), h);
      if (h) halt_cycles($urandom_range(1, 3));
      if (h || dut.state == 3'd3) reset_cycles($urandom_range(1, 2));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    n_tests++;
    if (act_retires != exp_retires) begin
      n_fail++;
      $display("FAIL retire_count: got %0d expected %0d", act_retires, exp_retires);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
